// File: rtl/sdram_read_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdram_read_ctrl_if : SDRAM command/data bus and ping-pong FIFO handshake |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface sdram_read_ctrl_if;
  logic [2:0]  command;
  logic [11:0] address;
  logic [1:0]  bank;
  logic [15:0] data_in;
  logic        enable;
  logic        idle;
  logic        auto_refresh;
  logic        wait_for_refresh;
  logic [21:0] app_address;
  logic        fifo_reset;
  logic [31:0] fifo_data;
  logic        fifo_write;
  logic [1:0]  fifo_ready;
  logic [1:0]  fifo_activate;
  logic [23:0] fifo_size;
  logic        starved;

  modport master (
    output command, address, bank, idle, wait_for_refresh,
           fifo_reset, fifo_data, fifo_write, fifo_activate,
    input  data_in, enable, auto_refresh, app_address,
           fifo_ready, fifo_size, starved
  );

  modport slave (
    input  command, address, bank, idle, wait_for_refresh,
           fifo_reset, fifo_data, fifo_write, fifo_activate,
    output data_in, enable, auto_refresh, app_address,
           fifo_ready, fifo_size, starved
  );
endinterface
`default_nettype wire

// File: rtl/sdram_read_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdram_read_ctrl : streams SDRAM words into a ping-pong read FIFO         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sdram_read_ctrl #(
  parameter int T_RCD       = 2,
  parameter int T_RP        = 2,
  parameter int CAS_LATENCY = 2
) (
  input wire                 clk,
  input wire                 rst,
  sdram_read_ctrl_if.master  bus
);

  localparam logic [3:0] c_st_idle         = 4'd0;
  localparam logic [3:0] c_st_get_fifo     = 4'd1;
  localparam logic [3:0] c_st_activate     = 4'd2;
  localparam logic [3:0] c_st_rcd_wait     = 4'd3;
  localparam logic [3:0] c_st_read         = 4'd4;
  localparam logic [3:0] c_st_capture      = 4'd5;
  localparam logic [3:0] c_st_decide       = 4'd6;
  localparam logic [3:0] c_st_precharge    = 4'd7;
  localparam logic [3:0] c_st_rp_wait      = 4'd8;
  localparam logic [3:0] c_st_refresh_wait = 4'd9;

  localparam logic [2:0] c_cmd_nop = 3'b111;
  localparam logic [2:0] c_cmd_act = 3'b011;
  localparam logic [2:0] c_cmd_rd  = 3'b101;
  localparam logic [2:0] c_cmd_pre = 3'b010;

  logic [3:0]  r_state, w_state_nx;
  logic [3:0]  r_after, w_after_nx;
  logic [21:0] r_ptr, w_ptr_nx;
  logic [23:0] r_count, w_count_nx;
  logic [7:0]  r_wait, w_wait_nx;
  logic [15:0] r_hi, w_hi_nx;
  logic [1:0]  r_act, w_act_nx;
  logic [31:0] r_fdata, w_fdata_nx;
  logic        r_fwrite, w_fwrite_nx;
  logic        r_freset, w_freset_nx;
  logic [2:0]  r_cmd, w_cmd_nx;
  logic [1:0]  r_bank, w_bank_nx;
  logic [11:0] r_addr, w_addr_nx;
  logic        w_unused;

  assign w_unused = ^{bus.starved, bus.app_address[0]};

  always_comb begin
    w_state_nx  = r_state;
    w_after_nx  = r_after;
    w_ptr_nx    = r_ptr;
    w_count_nx  = r_count;
    w_wait_nx   = r_wait;
    w_hi_nx     = r_hi;
    w_act_nx    = r_act;
    w_fdata_nx  = r_fdata;
    w_fwrite_nx = 1'b0;
    w_freset_nx = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (bus.auto_refresh) begin
          w_state_nx = c_st_refresh_wait;
        end else if (bus.enable) begin
          w_state_nx  = c_st_get_fifo;
          w_ptr_nx    = {bus.app_address[21:1], 1'b0};
          w_freset_nx = 1'b1;
        end
      end
      c_st_get_fifo: begin
        if (!bus.enable) begin
          w_state_nx = c_st_idle;
        end else if (bus.fifo_ready != 2'b00) begin
          w_act_nx   = bus.fifo_ready[0] ? 2'b01 : 2'b10;
          w_count_nx = 24'd0;
          w_state_nx = c_st_activate;
        end
      end
      c_st_activate: begin
        w_state_nx = c_st_rcd_wait;
        w_wait_nx  = 8'(T_RCD - 1);
      end
      c_st_rcd_wait: begin
        if (r_wait == 8'd0) w_state_nx = c_st_read;
        else                w_wait_nx  = r_wait - 8'd1;
      end
      c_st_read: begin
        w_state_nx = c_st_capture;
        w_wait_nx  = 8'(CAS_LATENCY);
      end
      // r_wait reaches 1 on the CAS_LATENCY-th edge after the READ cycle.
      c_st_capture: begin
        if (r_wait == 8'd0) begin
          w_fdata_nx  = {r_hi, bus.data_in};
          w_fwrite_nx = 1'b1;
          w_count_nx  = r_count + 24'd1;
          w_ptr_nx    = r_ptr + 22'd2;
          w_state_nx  = c_st_decide;
        end else begin
          if (r_wait == 8'd1) w_hi_nx = bus.data_in;
          w_wait_nx = r_wait - 8'd1;
        end
      end
      c_st_decide: begin
        w_state_nx = c_st_precharge;
        if (r_count == bus.fifo_size) begin
          w_act_nx   = 2'b00;
          w_after_nx = c_st_get_fifo;
        end else if (!bus.enable) begin
          w_act_nx   = 2'b00;
          w_after_nx = c_st_idle;
        end else if (bus.auto_refresh) begin
          w_after_nx = c_st_refresh_wait;
        end else if (r_ptr[7:0] == 8'h00) begin
          w_after_nx = c_st_activate;
        end else begin
          w_state_nx = c_st_read;
        end
      end
      c_st_precharge: begin
        w_state_nx = c_st_rp_wait;
        w_wait_nx  = 8'(T_RP - 1);
      end
      c_st_rp_wait: begin
        if (r_wait == 8'd0) w_state_nx = r_after;
        else                w_wait_nx  = r_wait - 8'd1;
      end
      c_st_refresh_wait: begin
        if (!bus.auto_refresh) begin
          if (r_act != 2'b00 && bus.enable) begin
            w_state_nx = c_st_activate;
          end else begin
            w_act_nx   = 2'b00;
            w_state_nx = c_st_idle;
          end
        end
      end
      default: w_state_nx = c_st_idle;
    endcase
  end

  // Command pins are registered from the next state so they line up with it.
  always_comb begin
    w_cmd_nx  = c_cmd_nop;
    w_bank_nx = 2'b00;
    w_addr_nx = 12'h000;
    case (w_state_nx)
      c_st_activate: begin
        w_cmd_nx  = c_cmd_act;
        w_bank_nx = w_ptr_nx[21:20];
        w_addr_nx = w_ptr_nx[19:8];
      end
      c_st_read: begin
        w_cmd_nx  = c_cmd_rd;
        w_bank_nx = w_ptr_nx[21:20];
        w_addr_nx = {4'h0, w_ptr_nx[7:0]};
      end
      c_st_precharge: begin
        w_cmd_nx  = c_cmd_pre;
        w_addr_nx = 12'h400;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_st_idle;
      r_after  <= c_st_idle;
      r_ptr    <= 22'd0;
      r_count  <= 24'd0;
      r_wait   <= 8'd0;
      r_hi     <= 16'd0;
      r_act    <= 2'b00;
      r_fdata  <= 32'd0;
      r_fwrite <= 1'b0;
      r_freset <= 1'b0;
      r_cmd    <= c_cmd_nop;
      r_bank   <= 2'b00;
      r_addr   <= 12'h000;
    end else begin
      r_state  <= w_state_nx;
      r_after  <= w_after_nx;
      r_ptr    <= w_ptr_nx;
      r_count  <= w_count_nx;
      r_wait   <= w_wait_nx;
      r_hi     <= w_hi_nx;
      r_act    <= w_act_nx;
      r_fdata  <= w_fdata_nx;
      r_fwrite <= w_fwrite_nx;
      r_freset <= w_freset_nx;
      r_cmd    <= w_cmd_nx;
      r_bank   <= w_bank_nx;
      r_addr   <= w_addr_nx;
    end
  end

  assign bus.command          = r_cmd;
  assign bus.bank             = r_bank;
  assign bus.address          = r_addr;
  assign bus.fifo_data        = r_fdata;
  assign bus.fifo_write       = r_fwrite;
  assign bus.fifo_reset       = r_freset;
  assign bus.fifo_activate    = r_act;
  assign bus.idle             = (r_state == c_st_idle) || (r_state == c_st_get_fifo) ||
                                (r_state == c_st_refresh_wait);
  assign bus.wait_for_refresh = (r_state == c_st_idle) || (r_state == c_st_refresh_wait);

endmodule
`default_nettype wire

// File: tb/tb_sdram_read_ctrl.sv
`default_nettype none
// Bench for sdram_read_ctrl: SDRAM data model, ping-pong FIFO ready model and
// an ordered event scoreboard of commands, FIFO flushes and FIFO words.
module tb_sdram_read_ctrl;
  localparam int CL = 2;
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_PRE = 3'b010;
  localparam logic [3:0] EV_FRESET = 4'd1, EV_ACT = 4'd2, EV_READ = 4'd3,
                         EV_PRE = 4'd4, EV_WORD = 4'd5;

  typedef struct packed { logic [3:0] kind; logic [33:0] val; } ev_t;
  typedef struct packed { logic [31:0] due; logic [15:0] d; } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  sdram_read_ctrl_if bus();

  sdram_read_ctrl #(.T_RCD(2), .T_RP(2), .CAS_LATENCY(CL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int reads_seen = 0;
  int cyc = 0;
  ev_t exp_q[$];
  rd_t pend_q[$];
  logic row_open = 1'b0;
  logic [11:0] open_row [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem(input logic [21:0] a);
    return a[15:0] ^ {4'h9, a[21:10]};
  endfunction

  function automatic void push(input logic [3:0] k, input logic [33:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Expected command/word trace for n words read from ptr start.
  task automatic push_stream(input logic [21:0] start, input int n, input logic [1:0] chan);
    logic [21:0] p;
    p = start;
    push(EV_ACT, {20'd0, p[21:8]});
    for (int i = 0; i < n; i++) begin
      push(EV_READ, {20'd0, p[21:20], 4'h0, p[7:0]});
      push(EV_WORD, {chan, mem(p), mem(p + 22'd1)});
      p = p + 22'd2;
      if (i == n - 1) begin
        push(EV_PRE, 34'd1);
      end else if (p[7:0] == 8'h00) begin
        push(EV_PRE, 34'd1);
        push(EV_ACT, {20'd0, p[21:8]});
      end
    end
  endtask

  task automatic observe(input logic [3:0] k, input logic [33:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", {26'd0, k, v}, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 64'(k), 64'(e.kind));
      check("event_value", 64'(v), 64'(e.val));
    end
  endtask

  // SDRAM data model, FIFO ready model and output monitor.
  initial begin
    logic [1:0]  prev_act;
    logic [21:0] wa;
    rd_t         r;
    prev_act = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      while (pend_q.size() > 0 && int'(pend_q[0].due) < cyc) void'(pend_q.pop_front());
      if (pend_q.size() > 0 && int'(pend_q[0].due) == cyc) begin
        bus.data_in = pend_q[0].d;
        void'(pend_q.pop_front());
      end else begin
        bus.data_in = 16'hDEAD;
      end
      if (!rst) begin
        row_open = 1'b0;
        prev_act = 2'b00;
      end else begin
        if (bus.fifo_reset) observe(EV_FRESET, 34'd0);
        case (bus.command)
          C_ACT: begin
            observe(EV_ACT, {20'd0, bus.bank, bus.address});
            row_open = 1'b1;
            open_row[bus.bank] = bus.address;
          end
          C_RD: begin
            observe(EV_READ, {20'd0, bus.bank, bus.address});
            reads_seen++;
            wa = {bus.bank, open_row[bus.bank], bus.address[7:0]};
            r.due = 32'(cyc + CL);     r.d = mem(wa);          pend_q.push_back(r);
            r.due = 32'(cyc + CL + 1); r.d = mem(wa + 22'd1);  pend_q.push_back(r);
          end
          C_PRE: begin
            observe(EV_PRE, {33'd0, bus.address[10]});
            row_open = 1'b0;
          end
          C_NOP: ;
          default: check("illegal_command", 64'(bus.command), 64'(C_NOP));
        endcase
        if (bus.fifo_write) observe(EV_WORD, {bus.fifo_activate, bus.fifo_data});
        if (bus.idle) check("row_open_while_idle", 64'(row_open), 64'd0);
        if (prev_act != 2'b00 && bus.fifo_activate == 2'b00)
          bus.fifo_ready = bus.fifo_ready & ~prev_act;
        prev_act = bus.fifo_activate;
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_reads(input string tag, input int target);
    int n;
    n = 0;
    while (reads_seen < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(reads_seen >= target), 64'd1);
  endtask

  task automatic wait_wfr(input string tag);
    int n;
    n = 0;
    while (!bus.wait_for_refresh && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(bus.wait_for_refresh), 64'd1);
  endtask

  task automatic start(input logic [21:0] app, input logic [23:0] size, input logic [1:0] ready);
    push(EV_FRESET, 34'd0);
    bus.app_address = app;
    bus.fifo_size   = size;
    bus.fifo_ready  = ready;
    bus.enable      = 1'b1;
  endtask

  task automatic stop_to_idle(input string tag);
    bus.enable = 1'b0;
    wait_wfr({tag, "_wfr"});
    check({tag, "_idle"}, 64'(bus.idle), 64'd1);
    check({tag, "_activate"}, 64'(bus.fifo_activate), 64'd0);
    check({tag, "_cmd"}, 64'(bus.command), 64'(C_NOP));
  endtask

  initial begin
    int base;
    bus.data_in      = 16'd0;
    bus.enable       = 1'b0;
    bus.auto_refresh = 1'b0;
    bus.app_address  = 22'd0;
    bus.fifo_ready   = 2'b00;
    bus.fifo_size    = 24'd0;
    bus.starved      = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_command", 64'(bus.command), 64'(C_NOP));
    check("rst_idle", 64'(bus.idle), 64'd1);
    check("rst_wfr", 64'(bus.wait_for_refresh), 64'd1);
    check("rst_activate", 64'(bus.fifo_activate), 64'd0);
    check("rst_write", 64'(bus.fifo_write), 64'd0);
    check("rst_fifo_reset", 64'(bus.fifo_reset), 64'd0);
    check("rst_address", 64'({bus.bank, bus.address}), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic stream then ping-pong onto the second channel
    start(22'h012340, 24'd4, 2'b11);
    push_stream(22'h012340, 4, 2'b01);
    push_stream(22'h012348, 4, 2'b10);
    wait_drain("pingpong_drain");
    stop_to_idle("pingpong_stop");

    // Refresh in the middle of a channel
    base = reads_seen;
    start(22'h205510, 24'd6, 2'b01);
    push_stream(22'h205510, 3, 2'b01);
    wait_reads("refresh_reads", base + 3);
    bus.auto_refresh = 1'b1;
    wait_drain("refresh_pre_drain");
    wait_wfr("refresh_wfr");
    repeat (4) @(negedge clk);
    check("refresh_idle", 64'(bus.idle), 64'd1);
    check("refresh_wfr_held", 64'(bus.wait_for_refresh), 64'd1);
    check("refresh_channel_kept", 64'(bus.fifo_activate), 64'd1);
    push_stream(22'h205516, 3, 2'b01);
    bus.auto_refresh = 1'b0;
    wait_drain("refresh_resume_drain");
    stop_to_idle("refresh_stop");

    // Row crossing inside a bank, then full address wrap
    start(22'h37FFFE, 24'd2, 2'b10);
    push_stream(22'h37FFFE, 2, 2'b10);
    wait_drain("rowcross_drain");
    stop_to_idle("rowcross_stop");
    start(22'h3FFFFF, 24'd2, 2'b01);
    push_stream(22'h3FFFFE, 2, 2'b01);
    wait_drain("wrap_drain");
    stop_to_idle("wrap_stop");

    // Disable after two of eight words, then re-enable at a new address
    base = reads_seen;
    start(22'h0ABC20, 24'd8, 2'b01);
    push_stream(22'h0ABC20, 2, 2'b01);
    wait_reads("disable_reads", base + 2);
    bus.enable = 1'b0;
    wait_drain("disable_drain");
    wait_wfr("disable_wfr");
    check("disable_activate", 64'(bus.fifo_activate), 64'd0);
    base = reads_seen;
    start(22'h0ABC31, 24'd8, 2'b01);
    push_stream(22'h0ABC30, 1, 2'b01);
    wait_reads("reenable_reads", base + 1);
    bus.enable = 1'b0;
    wait_drain("reenable_drain");
    stop_to_idle("reenable_stop");

    // Reset asserted while a word is in flight
    start(22'h000100, 24'd4, 2'b01);
    push(EV_ACT, {20'd0, 14'h0001});
    push(EV_READ, {20'd0, 2'b00, 4'h0, 8'h00});
    wait_drain("midrst_drain");
    rst = 1'b0;
    bus.enable = 1'b0;
    #1;
    check("midrst_command", 64'(bus.command), 64'(C_NOP));
    check("midrst_activate", 64'(bus.fifo_activate), 64'd0);
    check("midrst_idle", 64'(bus.idle), 64'd1);
    check("midrst_data", 64'(bus.fifo_data), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_strobe", 64'(bus.fifo_write), 64'd0);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst_wfr", 64'(bus.wait_for_refresh), 64'd1);
    check("postrst_command", 64'(bus.command), 64'(C_NOP));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
